// File: rtl/crc_32_frame_ctrl_if.sv
// Byte-stream handshake bundle used on both sides of crc_32_frame_ctrl.
//   valid : producer has a byte
//   ready : consumer accepts (transfer when valid && ready)
//   data  : payload byte
//   last  : final byte of frame
// master = byte producer, slave = byte consumer.
interface crc_32_frame_ctrl_if;
  logic       valid;
  logic       ready;
  logic [7:0] data;
  logic       last;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/crc_32_frame_ctrl.sv
// Frame-level CRC-32/IEEE sequencer.
// Forwards a last-framed byte stream with zero latency. In append mode
// (mode=0) it appends the 4-byte FCS LSB-first. In check mode (mode=1) it
// validates a trailing FCS by residue. It also reports per-frame status and
// keeps saturating frame/error counters.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   mode           : 0 append / 1 check, latched on first byte of frame
//   in_stream      : upstream byte stream (slave side)
//   out_stream     : downstream byte stream (master side)
//   status_valid   : one-cycle pulse per completed frame
//   crc_ok, len_err: frame result, held until next frame completes
//   crc_value      : final CRC of last completed frame (held)
//   cnt_clr        : synchronous clear of both counters
//   frame_cnt      : completed frames (saturating)
//   err_cnt        : frames with crc_ok=0 (saturating)
module crc_32_frame_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mode,
  crc_32_frame_ctrl_if.slave    in_stream,
  crc_32_frame_ctrl_if.master   out_stream,
  output logic                  status_valid,
  output logic                  crc_ok,
  output logic                  len_err,
  output logic [31:0]           crc_value,
  input  logic                  cnt_clr,
  output logic [CNT_W-1:0]      frame_cnt,
  output logic [CNT_W-1:0]      err_cnt
);

  localparam logic [31:0] CRC_POLY          = 32'h04C11DB7;
  localparam logic [31:0] CRC_INITIAL_VALUE = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE       = 32'hC704DD7B;
  localparam logic [2:0]  MIN_CHECK_LEN     = 3'd5;

  typedef enum logic [1:0] {IDLE, DATA, FCS, STAT} state_t;

  state_t      state, state_next;
  logic [31:0] crc_reg;
  logic [2:0]  byte_cnt;
  logic [1:0]  fcs_idx;
  logic        mode_q;

  logic        in_ready_c, out_valid_c, out_data_last_c;
  logic [7:0]  out_data_c;
  logic        in_fire, out_fire, mode_eff;
  logic [31:0] crc_upd, final_cur, final_upd;
  logic [2:0]  cnt_inc, cnt_fin;
  logic [7:0]  fcs_byte;

  // Byte is bit-reflected, i.e. in_data[0] enters the MSB-first shifter first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int unsigned i = 0; i < 8; i++) begin
      if (r[31] ^ b[i]) r = {r[30:0], 1'b0} ^ CRC_POLY;
      else              r = {r[30:0], 1'b0};
    end
    return r;
  endfunction

  function automatic logic [31:0] crc_final(input logic [31:0] c);
    logic [31:0] rev;
    for (int unsigned i = 0; i < 32; i++) rev[i] = c[31-i];
    return ~rev;
  endfunction

  assign in_stream.ready  = in_ready_c;
  assign out_stream.valid = out_valid_c;
  assign out_stream.data  = out_data_c;
  assign out_stream.last  = out_data_last_c;

  assign in_fire   = in_stream.valid && in_ready_c;
  assign out_fire  = out_valid_c && out_stream.ready;
  // The first byte of a frame uses the live mode input; later bytes the latched copy.
  assign mode_eff  = (state == IDLE) ? mode : mode_q;
  assign crc_upd   = crc_byte(crc_reg, in_stream.data);
  assign final_cur = crc_final(crc_reg);
  assign final_upd = crc_final(crc_upd);
  assign cnt_inc   = (byte_cnt == MIN_CHECK_LEN) ? byte_cnt : byte_cnt + 3'd1;
  assign cnt_fin   = (state == IDLE) ? 3'd1 : cnt_inc;

  always_comb begin
    fcs_byte = final_cur[7:0];
    unique case (fcs_idx)
      2'd0: fcs_byte = final_cur[7:0];
      2'd1: fcs_byte = final_cur[15:8];
      2'd2: fcs_byte = final_cur[23:16];
      2'd3: fcs_byte = final_cur[31:24];
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE, DATA: begin
        if (in_fire) begin
          if (in_stream.last) state_next = mode_eff ? STAT : FCS;
          else                state_next = DATA;
        end
      end
      FCS:  if (out_fire && fcs_idx == 2'd3) state_next = STAT;
      STAT: state_next = IDLE;
    endcase
  end

  // Output logic; in IDLE/DATA the stream passes straight through.
  always_comb begin
    in_ready_c      = 1'b0;
    out_valid_c     = 1'b0;
    out_data_c      = '0;
    out_data_last_c = 1'b0;
    status_valid    = 1'b0;
    unique case (state)
      IDLE, DATA: begin
        in_ready_c      = out_stream.ready && !rst;
        out_valid_c     = in_stream.valid && !rst;
        out_data_c      = in_stream.data;
        out_data_last_c = in_stream.last && mode_eff;
      end
      FCS: begin
        out_valid_c     = 1'b1;
        out_data_c      = fcs_byte;
        out_data_last_c = (fcs_idx == 2'd3);
      end
      STAT: status_valid = 1'b1;
    endcase
  end

  // Datapath: CRC register, counters, frame results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_reg   <= CRC_INITIAL_VALUE;
      byte_cnt  <= '0;
      fcs_idx   <= '0;
      mode_q    <= 1'b0;
      crc_ok    <= 1'b0;
      len_err   <= 1'b0;
      crc_value <= '0;
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_fire) begin
            crc_reg  <= crc_upd;
            byte_cnt <= 3'd1;
            mode_q   <= mode;
            fcs_idx  <= '0;
          end
        end
        DATA: begin
          if (in_fire) begin
            crc_reg  <= crc_upd;
            byte_cnt <= cnt_inc;
          end
        end
        FCS:  if (out_fire) fcs_idx <= fcs_idx + 2'd1;
        STAT: crc_reg <= CRC_INITIAL_VALUE;
      endcase

      // Results are captured on entry to STAT so they are valid alongside
      // status_valid; check mode must fold in the final byte being accepted.
      if (state_next == STAT && state != STAT) begin
        if (state == FCS) begin
          crc_ok    <= 1'b1;
          len_err   <= 1'b0;
          crc_value <= final_cur;
        end else begin
          len_err   <= (cnt_fin < MIN_CHECK_LEN);
          crc_ok    <= !(cnt_fin < MIN_CHECK_LEN) && (crc_upd == CRC_RESIDUE);
          crc_value <= final_upd;
        end
      end

      if (cnt_clr) begin
        frame_cnt <= '0;
        err_cnt   <= '0;
      end else if (state == STAT) begin
        if (frame_cnt != '1)           frame_cnt <= frame_cnt + 1'b1;
        if (!crc_ok && err_cnt != '1)  err_cnt   <= err_cnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/crc_32_frame_ctrl.md
Name: crc_32_frame_ctrl

Overview:
- Frame-level sequencer around the byte-wise CRC-32 update, using CRC_POLY, CRC_INITIAL_VALUE, byte reflection and final reverse-and-invert from the shared CRC package.
- Accepts a byte stream framed by in_last and forwards it downstream with zero latency.
- Append mode: generates and appends the 4-byte FCS.
- Check mode: validates a trailing FCS by residue.
- Sits between the MAC-side byte source and the link-side byte sink; reports per-frame status and keeps frame/error counters.

Parameters:
- CNT_W, 16, width of frame_cnt and err_cnt (saturating).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- mode  in  1  0 = append FCS, 1 = check FCS; sampled on first accepted byte of a frame.
- in_valid  in  1  input byte valid.
- in_ready  out  1  input byte accepted when in_valid && in_ready.
- in_data  in  8  input byte.
- in_last  in  1  final byte of frame.
- out_valid  out  1  output byte valid.
- out_ready  in  1  downstream accepts.
- out_data  out  8  output byte.
- out_last  out  1  final output byte of frame.
- status_valid  out  1  one-cycle pulse per completed frame.
- crc_ok  out  1  frame result, valid with status_valid.
- len_err  out  1  check-mode frame shorter than 5 bytes, valid with status_valid.
- crc_value  out  32  final CRC of last completed frame (held).
- cnt_clr  in  1  synchronous clear of both counters.
- frame_cnt  out  CNT_W  completed frames, saturating.
- err_cnt  out  CNT_W  frames with crc_ok=0, saturating.

Behaviour:
- CRC definition:
  - CRC-32/IEEE: register init 32'hFFFFFFFF.
  - Each byte is bit-reflected, then shifted MSB-first through poly 32'h04C11DB7.
  - Final CRC = bitwise NOT of the bit-reversed register.
  - "123456789" gives 32'hCBF43926.
- Reset: FSM IDLE, CRC register 32'hFFFFFFFF. in_ready=0 during reset. All outputs 0: out_valid, out_last, status_valid, crc_ok, len_err, crc_value, frame_cnt, err_cnt.
- FSM states: IDLE, DATA, FCS, STAT.
- IDLE:
  - in_ready=out_ready; out_valid=in_valid; out_data=in_data.
  - On the first accepted byte: latch mode, update CRC from init, byte count=1, go to DATA.
  - If that byte has in_last: go directly to the end-of-data handling below.
- DATA:
  - Combinational pass-through: out_valid=in_valid, in_ready=out_ready, out_data=in_data.
  - Each accepted byte updates the CRC register; the 3-bit byte counter saturates at 5.
- End of data (accepted byte with in_last):
  - Append mode: out_last=0 on that byte; go to FCS.
  - Check mode: out_last=in_last; go to STAT.
- FCS (append only):
  - in_ready=0; out_valid=1; emit final CRC LSB-first (crc[7:0], [15:8], [23:16], [31:24]).
  - 2-bit index advances only on out_ready; out_data/out_last held stable while stalled.
  - out_last=1 on byte 3; after it is accepted, go to STAT.
- STAT:
  - One cycle; in_ready=0, out_valid=0; status_valid=1.
  - crc_value = final CRC.
  - Append: crc_ok=1, len_err=0.
  - Check: len_err=(byte count<5); crc_ok = !len_err && register==32'hC704DD7B (final CRC == 32'h2144DF1C).
  - frame_cnt+1; err_cnt+1 if !crc_ok. Both saturate at all-ones.
  - Return to IDLE with register=32'hFFFFFFFF.
  - crc_ok/len_err hold until the next STAT.
- Timing: status_valid occurs the cycle after the final output byte handshake.
- mode changes mid-frame are ignored.
- cnt_clr: clears both counters next edge; cnt_clr in the same cycle as STAT → counters 0 (clear wins).
- Async rst mid-frame: immediate return to reset state. The partial frame is lost; no status, no counters.
- Stall: in_valid=0 or out_ready=0 causes no CRC update and no state change.

Test Plan:
- Append mode, "123456789" (0x31..0x39, in_last on 0x39), out_ready=1 → output 9 data bytes then 26 39 F4 CB, out_last on CB. status_valid pulse with crc_ok=1, crc_value=32'hCBF43926, frame_cnt=1.
- Check mode, 31..39 26 39 F4 CB → pass-through unchanged, out_last on CB, crc_ok=1, len_err=0. Repeat with last byte CA → crc_ok=0, err_cnt=1.
- Check mode, 4-byte frame 00 00 00 00 → len_err=1, crc_ok=0, err_cnt increments.
- Append mode, single byte 0x00 → FCS bytes 8D EF 02 D2 (CRC 32'hD202EF8D). Random out_ready deassertion during FCS → out_data stable while stalled, no bytes dropped or duplicated.
- Async rst asserted after 4 bytes of a frame, then a fresh "123456789" append frame → no status for the aborted frame, second frame gives 32'hCBF43926, frame_cnt=1.
- CNT_W=2: 5 bad check frames → err_cnt saturates at 3. cnt_clr coincident with STAT → both counters 0.
